// File: rtl/fsbl_spi_loader.sv
// First-stage boot loader: streams 32-bit words from SPI NOR flash (READ 0x03,
// mode 0) and writes them little-endian into instruction memory.
module fsbl_spi_loader #(
  parameter int unsigned CLK_DIV  = 2,
  parameter logic [31:0] DST_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fsbl_load_en,
  input  logic [31:0] fsbl_src_addr,
  output logic        fsbl_data_done,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        imem_wr_en,
  output logic [31:0] imem_wr_addr,
  output logic [31:0] imem_wr_data,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    ADDR  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    STOP  = 3'd5
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] READ_CMD = 8'h03;

  // Flash returns the lowest-addressed byte first; it lands in the LSB of the word.
  function automatic logic [31:0] swap_bytes(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  state_t      state_r, state_s;
  logic [7:0]  div_r, div_s;
  logic [4:0]  bit_r, bit_s;
  logic [31:0] sh_out_r, sh_out_s;
  logic [31:0] sh_in_r, sh_in_s;
  logic [29:0] word_r, word_s;
  logic        sclk_r, sclk_s;
  logic        cs_n_r, cs_n_s;
  logic        mosi_r, mosi_s;
  logic        wr_en_r, wr_en_s;
  logic        done_r, done_s;
  logic        busy_r, busy_s;
  logic [31:0] wr_addr_r, wr_addr_s;
  logic [31:0] wr_data_r, wr_data_s;
  logic        tick_s;
  logic        unused_src_s;

  assign unused_src_s = ^fsbl_src_addr[31:24];

  // Next-state, SPI bit engine and IMEM write decode.
  always_comb begin
    state_s   = state_r;
    div_s     = div_r;
    bit_s     = bit_r;
    sh_out_s  = sh_out_r;
    sh_in_s   = sh_in_r;
    word_s    = word_r;
    sclk_s    = sclk_r;
    cs_n_s    = cs_n_r;
    mosi_s    = mosi_r;
    wr_en_s   = 1'b0;
    done_s    = 1'b0;
    wr_addr_s = wr_addr_r;
    wr_data_s = wr_data_r;
    tick_s    = (div_r == DIV_LAST);
    case (state_r)
      IDLE: begin
        if (fsbl_load_en) begin
          state_s  = CMD;
          cs_n_s   = 1'b0;
          sclk_s   = 1'b0;
          div_s    = 8'd0;
          bit_s    = 5'd0;
          word_s   = 30'd0;
          sh_out_s = {READ_CMD, fsbl_src_addr[23:0]};
          mosi_s   = READ_CMD[7];
        end else begin
          cs_n_s = 1'b1;
          sclk_s = 1'b0;
          mosi_s = 1'b0;
        end
      end
      CMD, ADDR, DATA: begin
        if (!fsbl_load_en) begin
          state_s = STOP;
          cs_n_s  = 1'b1;
          sclk_s  = 1'b0;
          mosi_s  = 1'b0;
          div_s   = 8'd0;
        end else if (!tick_s) begin
          div_s = div_r + 8'd1;
        end else if (!sclk_r) begin
          div_s   = 8'd0;
          sclk_s  = 1'b1;
          sh_in_s = (state_r == DATA) ? {sh_in_r[30:0], spi_miso} : sh_in_r;
        end else begin
          // Falling sclk closes a bit; mosi only moves here.
          div_s  = 8'd0;
          sclk_s = 1'b0;
          bit_s  = bit_r + 5'd1;
          if (state_r != DATA) begin
            mosi_s   = (bit_r == 5'd31) ? 1'b0 : sh_out_r[30];
            sh_out_s = {sh_out_r[30:0], 1'b0};
            state_s  = (bit_r == 5'd31) ? DATA : ((bit_r == 5'd7) ? ADDR : state_r);
          end else if (bit_r == 5'd31) begin
            state_s   = WRITE;
            wr_en_s   = 1'b1;
            done_s    = 1'b1;
            wr_addr_s = DST_BASE + {word_r, 2'b00};
            wr_data_s = swap_bytes(sh_in_r);
          end else begin
            state_s = DATA;
          end
        end
      end
      WRITE: begin
        word_s = word_r + 30'd1;
        div_s  = 8'd0;
        if (fsbl_load_en) begin
          state_s = DATA;
        end else begin
          state_s = STOP;
          cs_n_s  = 1'b1;
          sclk_s  = 1'b0;
          mosi_s  = 1'b0;
        end
      end
      STOP: begin
        if (tick_s) begin
          state_s = IDLE;
          div_s   = 8'd0;
        end else begin
          div_s = div_r + 8'd1;
        end
      end
      default: begin
        state_s = IDLE;
        cs_n_s  = 1'b1;
        sclk_s  = 1'b0;
        mosi_s  = 1'b0;
        div_s   = 8'd0;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      div_r     <= 8'd0;
      bit_r     <= 5'd0;
      sh_out_r  <= 32'd0;
      sh_in_r   <= 32'd0;
      word_r    <= 30'd0;
      sclk_r    <= 1'b0;
      cs_n_r    <= 1'b1;
      mosi_r    <= 1'b0;
      wr_en_r   <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
      wr_addr_r <= DST_BASE;
      wr_data_r <= 32'd0;
    end else begin
      state_r   <= state_s;
      div_r     <= div_s;
      bit_r     <= bit_s;
      sh_out_r  <= sh_out_s;
      sh_in_r   <= sh_in_s;
      word_r    <= word_s;
      sclk_r    <= sclk_s;
      cs_n_r    <= cs_n_s;
      mosi_r    <= mosi_s;
      wr_en_r   <= wr_en_s;
      done_r    <= done_s;
      busy_r    <= busy_s;
      wr_addr_r <= wr_addr_s;
      wr_data_r <= wr_data_s;
    end
  end

  assign spi_sclk       = sclk_r;
  assign spi_cs_n       = cs_n_r;
  assign spi_mosi       = mosi_r;
  assign imem_wr_en     = wr_en_r;
  assign fsbl_data_done = done_r;
  assign imem_wr_addr   = wr_addr_r;
  assign imem_wr_data   = wr_data_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_fsbl_spi_loader.sv
// Bench for fsbl_spi_loader: two instances (CLK_DIV=2/base 0, CLK_DIV=1/base FFFF_FFFC)
// each driven by a behavioural SPI flash holding random bytes.
module tb_fsbl_spi_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  load_en = 2'b00;
  logic [31:0] src_addr = 32'h0010_0000;
  logic [7:0]  fmem [256];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // Free-running cycle stamp for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Word k of the stream: four flash bytes starting at src + 4k, first byte in the LSB.
  function automatic logic [31:0] exp_word(input int k);
    int a;
    a = int'(src_addr[7:0]) + 4 * k;
    return {fmem[(a + 3) % 256], fmem[(a + 2) % 256], fmem[(a + 1) % 256], fmem[a % 256]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_ch
    localparam int unsigned CD   = (g == 0) ? 2 : 1;
    localparam logic [31:0] BASE = (g == 0) ? 32'h0000_0000 : 32'hFFFF_FFFC;

    logic        done, sclk, cs_n, mosi, wr_en, busy;
    logic        miso = 1'b0;
    logic [31:0] wr_addr, wr_data;
    logic        sclk_q = 1'b0;
    logic        cs_q = 1'b1;
    logic [31:0] cap = 32'd0;
    int          rc = 0;
    int          last_rise = 0, period = 0, first_rise = 0, cs_fall = 0, adr_end = 0;
    int          mosi_bad = 0, done_cnt = 0, stray_done = 0;
    int          wr_cyc [$];
    logic [31:0] q_addr [$];
    logic [31:0] q_data [$];

    fsbl_spi_loader #(.CLK_DIV(CD), .DST_BASE(BASE)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fsbl_load_en   (load_en[g]),
      .fsbl_src_addr  (src_addr),
      .fsbl_data_done (done),
      .spi_sclk       (sclk),
      .spi_cs_n       (cs_n),
      .spi_mosi       (mosi),
      .spi_miso       (miso),
      .imem_wr_en     (wr_en),
      .imem_wr_addr   (wr_addr),
      .imem_wr_data   (wr_data),
      .busy           (busy)
    );

    // Flash model and write logger, sampling mid-cycle.
    always @(negedge clk) begin
      if (cs_n) begin
        rc <= 0;
      end else begin
        if (cs_q) cs_fall <= cyc;
        if (sclk && !sclk_q) begin
          if (rc < 32) cap <= {cap[30:0], mosi};
          else if (mosi) mosi_bad <= mosi_bad + 1;
          if (rc == 0) first_rise <= cyc;
          period    <= cyc - last_rise;
          last_rise <= cyc;
          rc        <= rc + 1;
        end
        if (!sclk && sclk_q) begin
          if (rc == 32) adr_end <= cyc;
          if (rc >= 32) miso <= fmem[(int'(cap[7:0]) + (rc - 32) / 8) % 256][7 - ((rc - 32) % 8)];
        end
      end
      if (wr_en) begin
        q_addr.push_back(wr_addr);
        q_data.push_back(wr_data);
        wr_cyc.push_back(cyc);
      end
      if (done) done_cnt <= done_cnt + 1;
      if (done != wr_en) stray_done <= stray_done + 1;
      sclk_q <= sclk;
      cs_q   <= cs_n;
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) fmem[i] = 8'($urandom_range(0, 255));
    fmem[0] = 8'h13; fmem[1] = 8'h05; fmem[2] = 8'h00; fmem[3] = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cs_n",    32'(g_ch[0].cs_n),  32'd1);
    chk("rst_sclk",    32'(g_ch[0].sclk),  32'd0);
    chk("rst_mosi",    32'(g_ch[0].mosi),  32'd0);
    chk("rst_busy",    32'(g_ch[0].busy),  32'd0);
    chk("rst_wr_en",   32'(g_ch[0].wr_en), 32'd0);
    chk("rst_done",    32'(g_ch[0].done),  32'd0);
    chk("rst_wr_addr", g_ch[0].wr_addr,    32'h0000_0000);
    chk("rst_wr_data", g_ch[0].wr_data,    32'h0000_0000);
    chk("rst_wr_addr1", g_ch[1].wr_addr,   32'hFFFF_FFFC);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_cs_n", 32'(g_ch[0].cs_n), 32'd1);

    // Stream three words, then drop the request
    load_en[0] = 1'b1;
    @(negedge clk);
    chk("cs_fall_1cyc", 32'(g_ch[0].cs_n), 32'd0);
    chk("busy_run",     32'(g_ch[0].busy), 32'd1);
    for (int i = 0; i < 1000 && g_ch[0].q_addr.size() < 1; i++) @(negedge clk);
    chk("w0_seen", 32'(g_ch[0].q_addr.size()), 32'd1);
    chk("cmd_addr_bits", g_ch[0].cap, 32'h0310_0000);
    chk("first_rise", 32'(g_ch[0].first_rise - g_ch[0].cs_fall), 32'd2);
    chk("sclk_period_div2", 32'(g_ch[0].period), 32'd4);
    chk("addr_to_write", 32'(g_ch[0].wr_cyc[0] - g_ch[0].adr_end), 32'd128);
    chk("w0_data_fixed", g_ch[0].q_data[0], 32'h0000_0513);
    for (int i = 0; i < 1000 && g_ch[0].q_addr.size() < 3; i++) @(negedge clk);
    chk("w3_seen", 32'(g_ch[0].q_addr.size()), 32'd3);
    repeat (2) @(negedge clk);
    load_en[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("stop_cs_n", 32'(g_ch[0].cs_n), 32'd1);
    chk("stop_sclk", 32'(g_ch[0].sclk), 32'd0);
    repeat (6) @(negedge clk);
    chk("stop_busy", 32'(g_ch[0].busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("w%0d_addr", k), g_ch[0].q_addr[k], 32'(4 * k));
      chk($sformatf("w%0d_data", k), g_ch[0].q_data[k], exp_word(k));
    end

    // Abort at bit ~10 of word 0: no write
    load_en[0] = 1'b1;
    for (int i = 0; i < 1000 && g_ch[0].rc < 42; i++) @(negedge clk);
    chk("reach_bit10", 32'(g_ch[0].rc >= 42), 32'd1);
    load_en[0] = 1'b0;
    @(negedge clk);
    chk("abort_cs_n", 32'(g_ch[0].cs_n), 32'd1);
    repeat (300) @(negedge clk);
    chk("abort_no_write", 32'(g_ch[0].q_addr.size()), 32'd3);
    chk("done_cnt", 32'(g_ch[0].done_cnt), 32'd3);
    chk("stray_done", 32'(g_ch[0].stray_done), 32'd0);
    chk("mosi_idle_data", 32'(g_ch[0].mosi_bad), 32'd0);

    // Asynchronous reset mid-address, then a fresh stream
    load_en[0] = 1'b1;
    for (int i = 0; i < 1000 && g_ch[0].rc < 12; i++) @(negedge clk);
    chk("reach_addr", 32'(g_ch[0].rc >= 12), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_cs_n",    32'(g_ch[0].cs_n),  32'd1);
    chk("arst_sclk",    32'(g_ch[0].sclk),  32'd0);
    chk("arst_busy",    32'(g_ch[0].busy),  32'd0);
    chk("arst_wr_data", g_ch[0].wr_data,    32'h0000_0000);
    chk("arst_wr_addr", g_ch[0].wr_addr,    32'h0000_0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 1000 && g_ch[0].q_addr.size() < 4; i++) @(negedge clk);
    load_en[0] = 1'b0;
    chk("rst_restart_seen", 32'(g_ch[0].q_addr.size()), 32'd4);
    chk("rst_restart_cmd",  g_ch[0].cap, 32'h0310_0000);
    chk("rst_restart_addr", g_ch[0].q_addr[3], 32'h0000_0000);
    chk("rst_restart_data", g_ch[0].q_data[3], exp_word(0));

    // CLK_DIV=1 with the destination wrapping past 2^32
    load_en[1] = 1'b1;
    for (int i = 0; i < 1000 && g_ch[1].rc < 40; i++) @(negedge clk);
    chk("sclk_period_div1", 32'(g_ch[1].period), 32'd2);
    for (int i = 0; i < 1000 && g_ch[1].q_addr.size() < 2; i++) @(negedge clk);
    load_en[1] = 1'b0;
    repeat (20) @(negedge clk);
    chk("wrap_count", 32'(g_ch[1].q_addr.size()), 32'd2);
    chk("wrap_busy",  32'(g_ch[1].busy), 32'd0);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("wrap%0d_addr", k), g_ch[1].q_addr[k], 32'hFFFF_FFFC + 32'(4 * k));
      chk($sformatf("wrap%0d_data", k), g_ch[1].q_data[k], exp_word(k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsbl_spi_loader.md
FSBL_SPI_LOADER -- requirements
Module: fsbl_spi_loader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: SCLK half-period in clk cycles, legal range 1..255.
REQ-002 SHALL have parameter DST_BASE, default 32'h0000_0000: instruction-memory byte address of word 0.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port fsbl_load_en  input  1  level request to stream FSBL words from flash.
REQ-006 SHALL have port fsbl_src_addr  input  32  flash byte address of first word; only [23:0] used.
REQ-007 SHALL have port fsbl_data_done  output  1  one-cycle pulse per word written to IMEM.
REQ-008 SHALL have port spi_sclk  output  1  SPI clock, mode 0.
REQ-009 SHALL have port spi_cs_n  output  1  flash chip select, active-low.
REQ-010 SHALL have port spi_mosi  output  1  SPI serial data to flash.
REQ-011 SHALL have port spi_miso  input  1  SPI serial data from flash.
REQ-012 SHALL have port imem_wr_en  output  1  IMEM write strobe, one cycle.
REQ-013 SHALL have port imem_wr_addr  output  32  IMEM byte address.
REQ-014 SHALL have port imem_wr_data  output  32  IMEM write word.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, CMD, ADDR, DATA, WRITE, STOP.
REQ-017 IDLE: on fsbl_load_en=1, SHALL latch fsbl_src_addr[23:0], clear word index, enter CMD, and drive spi_cs_n low on the next edge (1-cycle latency).
REQ-018 SPI mode 0: sclk idles low; mosi changes only while sclk low; miso sampled on sclk rising; MSB first; each bit = 2*CLK_DIV clk cycles, first sclk rise CLK_DIV cycles after cs_n falls.
REQ-019 CMD SHALL shift 8'h03, then ADDR SHALL shift the latched 24-bit address; mosi SHALL be 0 outside CMD/ADDR.
REQ-020 DATA SHALL shift in 32 bits; the first received byte SHALL be imem_wr_data[7:0] and the fourth byte [31:24] (little-endian).
REQ-021 After bit 32, WRITE SHALL last exactly 1 cycle with imem_wr_en=1 and fsbl_data_done=1, imem_wr_addr = DST_BASE + 4*word_index, modulo 2^32.
REQ-022 After WRITE, the word index SHALL increment and the FSM SHALL re-enter DATA with cs_n held low (flash sequential stream); sclk low during WRITE.
REQ-023 In CMD, ADDR, DATA or WRITE, if fsbl_load_en=0 the FSM SHALL enter STOP next edge; a partial word SHALL be discarded with no write and no done pulse.
REQ-024 WRITE with fsbl_load_en=0 in the same cycle SHALL still complete its write, then enter STOP.
REQ-025 STOP SHALL drive cs_n high, sclk low, hold for CLK_DIV cycles, then enter IDLE; fsbl_load_en high in IDLE restarts from REQ-017 with word index 0.
REQ-026 imem_wr_addr/imem_wr_data SHALL hold their last written values outside WRITE.

Reset
REQ-027 On rst_n=0, asynchronously: state IDLE, spi_cs_n=1, spi_sclk=0, spi_mosi=0, imem_wr_en=0, fsbl_data_done=0, busy=0, imem_wr_addr=DST_BASE, imem_wr_data=0, word index 0.
REQ-028 Reset asserted mid-transfer SHALL abort immediately with no write; after release, a high fsbl_load_en SHALL start a fresh CMD phase.

Verification
REQ-029 CLK_DIV=2, src 32'h0010_0000, load_en held high -> cs_n falls 1 cycle later; mosi carries 03 10 00 00 over 128 clks.
REQ-030 Flash model returns bytes 13 05 00 00 -> imem_wr_data=32'h0000_0513 at imem_wr_addr=DST_BASE, done pulse 1 cycle, 128 clks after address end.
REQ-031 Stream 3 words, drop load_en 2 cycles after third done -> exactly 3 writes at +0,+4,+8; cs_n high within 2 cycles; busy low after STOP.
REQ-032 Drop load_en at bit 10 of word 0 -> no write, no done, cs_n high next edge.
REQ-033 Assert rst_n=0 mid-ADDR -> outputs at reset values in same cycle; re-release with load_en=1 -> full 03+address sequence restarts.
REQ-034 CLK_DIV=1 and DST_BASE=32'hFFFF_FFFC, 2 words -> sclk period 2 clks; second write address wraps to 32'h0000_0000.
